coin_collector: RTL and testbench

Front-end transaction stage that sits directly upstream of the vending-machine stage. It accumulates inserted coins into a 6-bit credit and launches exactly one single-cycle purchase request toward the vending stage. It then captures the vending stage's `moneyLeft`/`productReady` result and pays out change one coin per cycle. Because the vending stage evaluates its inputs on every clock edge, this block also holds the product select at the idle code `3'b111` whenever no request is active.

---
 rtl/coin_collector.sv | 147 ++++++++++++++
 tb/tb_coin_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_collector.sv
// Coin collector front-end: accumulates credit, issues one single-cycle purchase
// request to the vending stage, then returns change one greedy coin per cycle.
module coin_collector (
  input  logic       CLK,
  input  logic       RST,
  input  logic       coinValid,
  input  logic [1:0] coinType,
  input  logic       selValid,
  input  logic       selVm,
  input  logic [2:0] selProduct,
  input  logic       selSugar,
  input  logic       cancel,
  input  logic [5:0] moneyLeft,
  input  logic       productReady,
  output logic [5:0] money,
  output logic       vm,
  output logic [2:0] productID,
  output logic       sugar,
  output logic       busy,
  output logic       changeValid,
  output logic [1:0] changeCoin,
  output logic       coinReject,
  output logic       dispensed,
  output logic       purchaseFailed
);

  localparam int unsigned CreditW = 6;
  localparam logic [CreditW-1:0] MaxCredit = CreditW'(63);
  localparam logic [2:0] IdleProduct = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHANGE} state_t;

  state_t state, stateNext;
  logic [CreditW-1:0] credit, creditNext, creditAfter;
  logic [CreditW-1:0] remaining, remainingNext;
  logic [CreditW:0]   sumWide;
  logic       vmNext, sugarNext;
  logic [2:0] productNext;
  logic       rejectNext, dispNext, failNext;
  logic [1:0] greedyCoin;

  function automatic logic [CreditW-1:0] coinValue(input logic [1:0] c);
    case (c)
      2'b00:   coinValue = CreditW'(1);
      2'b01:   coinValue = CreditW'(5);
      2'b10:   coinValue = CreditW'(10);
      default: coinValue = CreditW'(20);
    endcase
  endfunction

  // 7-bit sum so the overflow check cannot wrap
  assign sumWide = {1'b0, credit} + {1'b0, coinValue(coinType)};

  // Largest coin not exceeding the outstanding change
  always_comb begin
    greedyCoin = 2'b00;
    if (remaining >= CreditW'(20))      greedyCoin = 2'b11;
    else if (remaining >= CreditW'(10)) greedyCoin = 2'b10;
    else if (remaining >= CreditW'(5))  greedyCoin = 2'b01;
  end

  assign money       = credit;
  assign busy        = (state != IDLE);
  assign changeValid = (state == CHANGE) && (remaining != '0);
  assign changeCoin  = changeValid ? greedyCoin : 2'b00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      credit         <= '0;
      remaining      <= '0;
      vm             <= 1'b0;
      productID      <= IdleProduct;
      sugar          <= 1'b0;
      coinReject     <= 1'b0;
      dispensed      <= 1'b0;
      purchaseFailed <= 1'b0;
    end else begin
      state          <= stateNext;
      credit         <= creditNext;
      remaining      <= remainingNext;
      vm             <= vmNext;
      productID      <= productNext;
      sugar          <= sugarNext;
      coinReject     <= rejectNext;
      dispensed      <= dispNext;
      purchaseFailed <= failNext;
    end
  end

  always_comb begin
    stateNext     = state;
    creditNext    = credit;
    creditAfter   = credit;
    remainingNext = remaining;
    vmNext        = vm;
    productNext   = productID;
    sugarNext     = sugar;
    rejectNext    = 1'b0;
    dispNext      = 1'b0;
    failNext      = 1'b0;
    case (state)
      IDLE: begin
        if (coinValid) begin
          if (sumWide <= {1'b0, MaxCredit}) creditAfter = sumWide[CreditW-1:0];
          else                              rejectNext  = 1'b1;
        end
        creditNext = creditAfter;
        // cancel takes priority over a purchase and refunds any coin added this cycle
        if (cancel) begin
          if (creditAfter != '0) begin
            remainingNext = creditAfter;
            stateNext     = CHANGE;
          end
        end else if (selValid) begin
          vmNext      = selVm;
          productNext = selProduct;
          sugarNext   = selSugar;
          stateNext   = ISSUE;
        end
      end
      ISSUE: begin
        rejectNext  = coinValid;
        productNext = IdleProduct;
        stateNext   = WAIT;
      end
      WAIT: begin
        rejectNext    = coinValid;
        remainingNext = moneyLeft;
        dispNext      = productReady;
        failNext      = !productReady;
        stateNext     = CHANGE;
      end
      CHANGE: begin
        rejectNext = coinValid;
        if (remaining != '0) begin
          remainingNext = remaining - coinValue(greedyCoin);
        end else begin
          creditNext = '0;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coin_collector.sv
// Directed self-checking bench for coin_collector; expected values hand-computed.
module tb_coin_collector;

  logic       CLK = 1'b0;
  logic       RST;
  logic       coinValid;
  logic [1:0] coinType;
  logic       selValid;
  logic       selVm;
  logic [2:0] selProduct;
  logic       selSugar;
  logic       cancel;
  logic [5:0] moneyLeft;
  logic       productReady;
  logic [5:0] money;
  logic       vm;
  logic [2:0] productID;
  logic       sugar;
  logic       busy;
  logic       changeValid;
  logic [1:0] changeCoin;
  logic       coinReject;
  logic       dispensed;
  logic       purchaseFailed;

  int nCompared   = 0;
  int nMismatched = 0;

  coin_collector dut (
    .CLK(CLK), .RST(RST), .coinValid(coinValid), .coinType(coinType),
    .selValid(selValid), .selVm(selVm), .selProduct(selProduct), .selSugar(selSugar),
    .cancel(cancel), .moneyLeft(moneyLeft), .productReady(productReady),
    .money(money), .vm(vm), .productID(productID), .sugar(sugar), .busy(busy),
    .changeValid(changeValid), .changeCoin(changeCoin), .coinReject(coinReject),
    .dispensed(dispensed), .purchaseFailed(purchaseFailed)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic insertCoin(input logic [1:0] t);
    coinValid = 1'b1;
    coinType  = t;
    tick();
    coinValid = 1'b0;
  endtask

  task automatic select(input logic v, input logic [2:0] p, input logic s);
    selValid   = 1'b1;
    selVm      = v;
    selProduct = p;
    selSugar   = s;
    tick();
    selValid   = 1'b0;
  endtask

  task automatic expectCoin(input string tag, input logic [1:0] c);
    checkVal({tag, "_valid"}, 32'(changeValid), 32'd1);
    checkVal({tag, "_coin"}, 32'(changeCoin), 32'(c));
    tick();
  endtask

  initial begin
    RST = 1'b1; coinValid = 1'b0; coinType = 2'b00; selValid = 1'b0;
    selVm = 1'b0; selProduct = 3'b000; selSugar = 1'b0; cancel = 1'b0;
    moneyLeft = 6'd0; productReady = 1'b0;
    #1;
    tick(); tick();
    RST = 1'b0;
    checkVal("rst_money", 32'(money), 32'd0);
    checkVal("rst_prod", 32'(productID), 32'd7);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_chg", 32'(changeValid), 32'd0);
    checkVal("rst_vm", 32'(vm), 32'd0);
    tick();

    // cancel with zero credit is ignored
    cancel = 1'b1; tick(); cancel = 1'b0;
    checkVal("cancel0_busy", 32'(busy), 32'd0);

    // T1: 10+10, exact purchase
    insertCoin(2'b10); insertCoin(2'b10);
    checkVal("t1_money", 32'(money), 32'd20);
    moneyLeft = 6'd0; productReady = 1'b1;
    select(1'b0, 3'b000, 1'b1);
    checkVal("t1_issue_prod", 32'(productID), 32'd0);
    checkVal("t1_issue_sugar", 32'(sugar), 32'd1);
    checkVal("t1_issue_busy", 32'(busy), 32'd1);
    tick();
    checkVal("t1_wait_prod", 32'(productID), 32'd7);
    tick();
    checkVal("t1_disp", 32'(dispensed), 32'd1);
    checkVal("t1_fail", 32'(purchaseFailed), 32'd0);
    checkVal("t1_nochg", 32'(changeValid), 32'd0);
    tick();
    checkVal("t1_disp_off", 32'(dispensed), 32'd0);
    checkVal("t1_idle", 32'(busy), 32'd0);
    checkVal("t1_money0", 32'(money), 32'd0);

    // T2: 20 in, coffee, 8 back as 5,1,1,1
    insertCoin(2'b11);
    moneyLeft = 6'd8; productReady = 1'b1;
    select(1'b1, 3'b011, 1'b0);
    checkVal("t2_vm", 32'(vm), 32'd1);
    checkVal("t2_prod", 32'(productID), 32'd3);
    tick(); tick();
    expectCoin("t2_c0", 2'b01);
    expectCoin("t2_c1", 2'b00);
    expectCoin("t2_c2", 2'b00);
    expectCoin("t2_c3", 2'b00);
    checkVal("t2_end_chg", 32'(changeValid), 32'd0);
    checkVal("t2_end_busy", 32'(busy), 32'd1);
    tick();
    checkVal("t2_idle", 32'(busy), 32'd0);
    checkVal("t2_money0", 32'(money), 32'd0);

    // T3: overflow reject, fill to 63, refund all
    insertCoin(2'b11); insertCoin(2'b11); insertCoin(2'b11);
    checkVal("t3_money60", 32'(money), 32'd60);
    insertCoin(2'b01);
    checkVal("t3_rej", 32'(coinReject), 32'd1);
    checkVal("t3_money_keep", 32'(money), 32'd60);
    insertCoin(2'b00);
    checkVal("t3_rej_off", 32'(coinReject), 32'd0);
    insertCoin(2'b00); insertCoin(2'b00);
    checkVal("t3_money63", 32'(money), 32'd63);
    cancel = 1'b1; tick(); cancel = 1'b0;
    expectCoin("t3_c0", 2'b11);
    expectCoin("t3_c1", 2'b11);
    expectCoin("t3_c2", 2'b11);
    expectCoin("t3_c3", 2'b00);
    expectCoin("t3_c4", 2'b00);
    expectCoin("t3_c5", 2'b00);
    checkVal("t3_end_chg", 32'(changeValid), 32'd0);
    tick();
    checkVal("t3_idle", 32'(busy), 32'd0);
    checkVal("t3_money0", 32'(money), 32'd0);

    // T4: coin and select together, vending stage refuses
    moneyLeft = 6'd5; productReady = 1'b0;
    coinValid = 1'b1; coinType = 2'b01;
    select(1'b0, 3'b000, 1'b0);
    coinValid = 1'b0;
    checkVal("t4_issue_money", 32'(money), 32'd5);
    checkVal("t4_issue_prod", 32'(productID), 32'd0);
    tick(); tick();
    checkVal("t4_fail", 32'(purchaseFailed), 32'd1);
    checkVal("t4_disp", 32'(dispensed), 32'd0);
    expectCoin("t4_c0", 2'b01);
    checkVal("t4_fail_off", 32'(purchaseFailed), 32'd0);
    checkVal("t4_end_chg", 32'(changeValid), 32'd0);
    tick();
    checkVal("t4_idle", 32'(busy), 32'd0);

    // T5: coin during WAIT refused, then reset during change
    insertCoin(2'b10);
    moneyLeft = 6'd15; productReady = 1'b1;
    select(1'b0, 3'b001, 1'b0);
    tick();
    coinValid = 1'b1; coinType = 2'b00;
    tick();
    coinValid = 1'b0;
    checkVal("t5_rej", 32'(coinReject), 32'd1);
    checkVal("t5_money_keep", 32'(money), 32'd10);
    checkVal("t5_c0_valid", 32'(changeValid), 32'd1);
    checkVal("t5_c0_coin", 32'(changeCoin), 32'd2);
    tick();
    checkVal("t5_c1_coin", 32'(changeCoin), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkVal("t5_rst_chg", 32'(changeValid), 32'd0);
    checkVal("t5_rst_money", 32'(money), 32'd0);
    checkVal("t5_rst_prod", 32'(productID), 32'd7);
    checkVal("t5_rst_busy", 32'(busy), 32'd0);
    tick();
    checkVal("t5_post_chg", 32'(changeValid), 32'd0);
    checkVal("t5_post_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
